// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: FSM state encoding, STATUS bit positions and the default word width.
// Kept separate so the SPI master can reuse the same encodings.
package spi_slave_pkg;

  localparam int unsigned DefaultDataWidth = 8;

  typedef enum logic {
    StIdle   = 1'b0,
    StActive = 1'b1
  } spi_state_e;

  localparam int unsigned StatRxValid = 0;
  localparam int unsigned StatTxFull  = 1;
  localparam int unsigned StatRxOvr   = 2;
  localparam int unsigned StatTxUdr   = 3;
  localparam int unsigned StatTxOvf   = 4;
  localparam int unsigned StatBusy    = 5;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle rise/fall pulses
// derived from the synchronized value.
module spi_sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < Stages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[Stages-1];
  end

  // Reset to the idle level of the line so release from reset produces no edge.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~prev_q;
  assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave (mode 0) with a one-word TX buffer, one-word RX holding register and sticky
// error flags; all SPI inputs are oversampled by the system clock.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  S_CLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  TX_WRITE,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_READ,
  input  logic                  STATUS_CLR,
  output logic [7:0]            STATUS
);

  localparam int unsigned CntW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk_i(CLK), .clr_i(CLR), .d_i(S_CLK), .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
    .clk_i(CLK), .clr_i(CLR), .d_i(CS), .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk_i(CLK), .clr_i(CLR), .d_i(MOSI), .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_s, cs_s, mosi_rise, mosi_fall};

  spi_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  reload_q, reload_d;
  logic                  tx_full_q, tx_full_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_ovr_q, rx_ovr_d;
  logic                  tx_udr_q, tx_udr_d;
  logic                  tx_ovf_q, tx_ovf_d;
  logic                  word_done, tx_load, tx_consume;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    tx_buf_d   = tx_buf_q;
    reload_d   = reload_q;
    tx_full_d  = tx_full_q;
    rx_valid_d = rx_valid_q;
    word_done  = 1'b0;
    tx_load    = 1'b0;

    case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d    = StActive;
          tx_load    = 1'b1;
          cnt_d      = '0;
          rx_shift_d = '0;
          reload_d   = 1'b0;
        end
      end
      StActive: begin
        if (cs_rise) begin
          // Partial word is dropped; the holding register keeps the last complete word.
          state_d    = StIdle;
          cnt_d      = '0;
          rx_shift_d = '0;
          reload_d   = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            if (cnt_q == LastBit) begin
              cnt_d     = '0;
              word_done = 1'b1;
              reload_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if (sclk_fall) begin
            if (reload_q) begin
              tx_load  = 1'b1;
              reload_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (tx_load) begin
      tx_shift_d = tx_full_q ? tx_buf_q : '0;
    end
    tx_consume = tx_load & tx_full_q;
    if (tx_consume) begin
      tx_full_d = 1'b0;
    end
    if (TX_WRITE && (!tx_full_q || tx_consume)) begin
      tx_buf_d  = TX_DATA;
      tx_full_d = 1'b1;
    end

    if (word_done) begin
      rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
      rx_valid_d = 1'b1;
    end else if (RX_READ) begin
      rx_valid_d = 1'b0;
    end

    // Setting events take priority over STATUS_CLR.
    rx_ovr_d = (rx_ovr_q & ~STATUS_CLR) | (word_done & rx_valid_q & ~RX_READ);
    tx_udr_d = (tx_udr_q & ~STATUS_CLR) | (tx_load & ~tx_full_q);
    tx_ovf_d = (tx_ovf_q & ~STATUS_CLR) | (TX_WRITE & tx_full_q & ~tx_consume);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      tx_buf_q   <= '0;
      reload_q   <= 1'b0;
      tx_full_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_udr_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      tx_buf_q   <= tx_buf_d;
      reload_q   <= reload_d;
      tx_full_q  <= tx_full_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_udr_q   <= tx_udr_d;
      tx_ovf_q   <= tx_ovf_d;
    end
  end

  always_comb begin
    MISO                = (state_q == StActive) & tx_shift_q[DATA_WIDTH-1];
    MISO_OE             = (state_q == StActive);
    RX_DATA             = rx_data_q;
    STATUS              = '0;
    STATUS[StatRxValid] = rx_valid_q;
    STATUS[StatTxFull]  = tx_full_q;
    STATUS[StatRxOvr]   = rx_ovr_q;
    STATUS[StatTxUdr]   = tx_udr_q;
    STATUS[StatTxOvf]   = tx_ovf_q;
    STATUS[StatBusy]    = (state_q == StActive);
  end

endmodule
